// File: rtl/ov5640_cfg_seq.sv
// OV5640 configuration sequencer: walks the register LUT and issues one I2C write per entry,
// with a power-up wait, a settle wait after a software reset write, and NACK retries.
module ov5640_cfg_seq #(
  parameter logic [19:0] PWRUP_CYCLES    = 20'd1000000,
  parameter logic [19:0] RST_WAIT_CYCLES = 20'd250000,
  parameter logic [1:0]  MAX_RETRY       = 2'd3,
  parameter logic [7:0]  TERM_DEV        = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [15:0] i2c_write_addr,
  output logic [7:0]  i2c_write_data,
  output logic        config_done,
  output logic        config_fail
);

  localparam logic [2:0] S_PWRUP   = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RSTWAIT = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_FAIL    = 3'd7;

  logic [2:0]  r_state;
  logic [19:0] r_cnt;
  logic [1:0]  r_retry;
  logic [9:0]  r_index;
  logic        r_req;
  logic [7:0]  r_dev;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic        r_done;
  logic        r_fail;

  logic w_isTerm;
  logic w_isSwReset;

  // A zero device byte means we have run past the populated part of the table.
  assign w_isTerm    = (lut_data[31:24] == TERM_DEV) || (lut_data[31:24] == 8'h00);
  assign w_isSwReset = (r_addr == 16'h3008) && r_data[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_PWRUP;
      r_cnt   <= '0;
      r_retry <= '0;
      r_index <= '0;
      r_req   <= 1'b0;
      r_dev   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == PWRUP_CYCLES - 20'd1) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_FETCH: begin
          if (w_isTerm) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dev   <= lut_data[31:24];
            r_addr  <= lut_data[23:8];
            r_data  <= lut_data[7:0];
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_req   <= 1'b1;
          r_state <= S_WAIT;
        end
        // Error wins over a simultaneous ack so a doubtful write is always repeated.
        S_WAIT: begin
          if (i2c_error) begin
            r_req <= 1'b0;
            if (r_retry < MAX_RETRY) begin
              r_retry <= r_retry + 2'd1;
              r_state <= S_REQ;
            end else begin
              r_fail  <= 1'b1;
              r_state <= S_FAIL;
            end
          end else if (i2c_write_req_ack) begin
            r_req   <= 1'b0;
            r_retry <= '0;
            if (w_isSwReset) begin
              r_cnt   <= '0;
              r_state <= S_RSTWAIT;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_RSTWAIT: begin
          if (r_cnt == RST_WAIT_CYCLES - 20'd1) begin
            r_cnt   <= '0;
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_NEXT: begin
          if (r_index == 10'd1023) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + 10'd1;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_req <= 1'b0;
        end
        default: begin
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign lut_index          = r_index;
  assign i2c_write_req      = r_req;
  assign i2c_slave_dev_addr = r_dev;
  assign i2c_write_addr     = r_addr;
  assign i2c_write_data     = r_data;
  assign config_done        = r_done;
  assign config_fail        = r_fail;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Directed bench for ov5640_cfg_seq: behavioural LUT, scripted I2C responder, hand-computed
// expectations for timing, field order, retries, reset abort and index saturation.
module tb_ov5640_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  lut_index;
  logic [31:0] lut_data;
  logic        i2c_write_req;
  logic        i2c_write_req_ack;
  logic        i2c_error;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_write_addr;
  logic [7:0]  i2c_write_data;
  logic        config_done;
  logic        config_fail;

  logic [31:0] lutMem [0:1023];

  int checks = 0;
  int errors = 0;

  int cycle;
  int reqCount;
  int firstReqCycle;
  int lowRun;
  int reqAge;
  int respMode;
  int entry1Nacks;
  int dualDone;
  int stableErr;
  logic prevReq;
  logic [7:0]  lastDev;
  logic [15:0] lastAddr;
  logic [7:0]  lastData;
  logic [7:0]  logDev  [0:1023];
  logic [15:0] logAddr [0:1023];
  logic [7:0]  logData [0:1023];
  int          logGap  [0:1023];

  ov5640_cfg_seq #(
    .PWRUP_CYCLES   (20'd10),
    .RST_WAIT_CYCLES(20'd20),
    .MAX_RETRY      (2'd3),
    .TERM_DEV       (8'hFF)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .lut_index         (lut_index),
    .lut_data          (lut_data),
    .i2c_write_req     (i2c_write_req),
    .i2c_write_req_ack (i2c_write_req_ack),
    .i2c_error         (i2c_error),
    .i2c_slave_dev_addr(i2c_slave_dev_addr),
    .i2c_write_addr    (i2c_write_addr),
    .i2c_write_data    (i2c_write_data),
    .config_done       (config_done),
    .config_fail       (config_fail)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // The LUT is purely combinational, exactly like the ROM the sequencer expects.
  assign lut_data = lutMem[lut_index];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadNominal();
    for (int i = 0; i < 1024; i++) lutMem[i] = 32'h0;
    lutMem[0] = 32'h78_310311;
    lutMem[1] = 32'h78_300882;
    lutMem[2] = 32'h78_300802;
    lutMem[3] = 32'hFF_FFFFFF;
  endtask

  // Hold reset for a few cycles and clear all monitor/responder bookkeeping.
  task automatic applyReset();
    rst = 1'b1;
    i2c_write_req_ack = 1'b0;
    i2c_error = 1'b0;
    reqCount = 0;
    firstReqCycle = -1;
    lowRun = 0;
    reqAge = 0;
    entry1Nacks = 0;
    dualDone = 0;
    stableErr = 0;
    prevReq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Release happens between edges, so the first edge after it is cycle 1.
  task automatic releaseReset();
    rst = 1'b0;
    cycle = 0;
    lowRun = 0;
    prevReq = 1'b0;
  endtask

  // One clock: log request edges, watch field stability, and play the I2C slave.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cycle++;
    i2c_write_req_ack = 1'b0;
    i2c_error = 1'b0;
    if (i2c_write_req && !prevReq) begin
      if (reqCount < 1024) begin
        logDev[reqCount]  = i2c_slave_dev_addr;
        logAddr[reqCount] = i2c_write_addr;
        logData[reqCount] = i2c_write_data;
        logGap[reqCount]  = lowRun;
      end
      if (reqCount == 0) firstReqCycle = cycle;
      reqCount++;
      reqAge = 0;
      lastDev  = i2c_slave_dev_addr;
      lastAddr = i2c_write_addr;
      lastData = i2c_write_data;
    end else if (i2c_write_req) begin
      if (i2c_slave_dev_addr != lastDev || i2c_write_addr != lastAddr || i2c_write_data != lastData)
        stableErr++;
      reqAge++;
    end
    if (i2c_write_req) lowRun = 0;
    else lowRun++;
    if (i2c_write_req && reqAge == 5) begin
      case (respMode)
        1: begin
          if (lut_index == 10'd1 && entry1Nacks < 2) begin
            i2c_error = 1'b1;
            entry1Nacks++;
          end else begin
            i2c_write_req_ack = 1'b1;
          end
        end
        2: i2c_error = 1'b1;
        3: begin
          if (lut_index == 10'd0 && dualDone == 0) begin
            i2c_write_req_ack = 1'b1;
            i2c_error = 1'b1;
            dualDone = 1;
          end else begin
            i2c_write_req_ack = 1'b1;
          end
        end
        default: i2c_write_req_ack = 1'b1;
      endcase
    end
    prevReq = i2c_write_req;
  endtask

  task automatic runUntilEnd(input int budget);
    int n;
    n = 0;
    while (!config_done && !config_fail && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("finished", {31'b0, config_done | config_fail}, 32'd1);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [31:0] exp);
    checkOutput(tag, {logDev[idx], logAddr[idx], logData[idx]}, exp);
  endtask

  initial begin
    rst = 1'b1;
    i2c_write_req_ack = 1'b0;
    i2c_error = 1'b0;
    respMode = 0;

    // Nominal table: order, fields, power-up latency and software-reset settle gap.
    loadNominal();
    applyReset();
    checkOutput("rstIndex", {22'b0, lut_index}, 32'd0);
    checkOutput("rstReq", {31'b0, i2c_write_req}, 32'd0);
    checkOutput("rstFields", {i2c_slave_dev_addr, i2c_write_addr, i2c_write_data}, 32'd0);
    checkOutput("rstDoneFail", {30'b0, config_done, config_fail}, 32'd0);
    releaseReset();
    runUntilEnd(300);
    checkOutput("nomFirstReq", firstReqCycle, 32'd12);
    checkOutput("nomReqCount", reqCount, 32'd3);
    checkWrite("nomWrite0", 0, 32'h78_310311);
    checkWrite("nomWrite1", 1, 32'h78_300882);
    checkWrite("nomWrite2", 2, 32'h78_300802);
    checkOutput("nomGap1", logGap[1], 32'd3);
    checkOutput("nomGap2", logGap[2], 32'd23);
    checkOutput("nomDone", {30'b0, config_done, config_fail}, 32'd2);
    checkOutput("nomIndex", {22'b0, lut_index}, 32'd3);
    checkOutput("nomStable", stableErr, 32'd0);

    // Entry 1 NACKed twice, then accepted.
    respMode = 1;
    applyReset();
    releaseReset();
    runUntilEnd(400);
    checkOutput("nackReqCount", reqCount, 32'd5);
    checkWrite("nackWrite1", 1, 32'h78_300882);
    checkWrite("nackWrite2", 2, 32'h78_300882);
    checkWrite("nackWrite3", 3, 32'h78_300882);
    checkWrite("nackWrite4", 4, 32'h78_300802);
    checkOutput("nackGap2", logGap[2], 32'd1);
    checkOutput("nackGap3", logGap[3], 32'd1);
    checkOutput("nackGap4", logGap[4], 32'd23);
    checkOutput("nackDone", {30'b0, config_done, config_fail}, 32'd2);

    // Every write NACKed: four attempts on entry 0, then a frozen failure.
    respMode = 2;
    applyReset();
    releaseReset();
    runUntilEnd(300);
    repeat (20) applyStimulus();
    checkOutput("failReqCount", reqCount, 32'd4);
    checkWrite("failWrite3", 3, 32'h78_310311);
    checkOutput("failFlags", {30'b0, config_done, config_fail}, 32'd1);
    checkOutput("failIndex", {22'b0, lut_index}, 32'd0);
    checkOutput("failReqLow", {31'b0, i2c_write_req}, 32'd0);

    // Ack and error in the same cycle count as an error.
    respMode = 3;
    applyReset();
    releaseReset();
    runUntilEnd(300);
    checkOutput("dualReqCount", reqCount, 32'd4);
    checkWrite("dualWrite1", 1, 32'h78_310311);
    checkOutput("dualGap1", logGap[1], 32'd1);
    checkWrite("dualWrite2", 2, 32'h78_300882);
    checkOutput("dualDone", {30'b0, config_done, config_fail}, 32'd2);

    // Reset while entry 2 is being requested drops req at once and restarts cleanly.
    respMode = 0;
    applyReset();
    releaseReset();
    begin
      int n;
      n = 0;
      while (!(i2c_write_req && lut_index == 10'd2) && n < 300) begin
        applyStimulus();
        n++;
      end
    end
    checkOutput("midReqSeen", {31'b0, i2c_write_req && lut_index == 10'd2}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstReq", {31'b0, i2c_write_req}, 32'd0);
    checkOutput("midRstIndex", {22'b0, lut_index}, 32'd0);
    applyReset();
    releaseReset();
    begin
      int n;
      n = 0;
      while (reqCount == 0 && n < 50) begin
        applyStimulus();
        n++;
      end
    end
    checkOutput("restartFirstReq", firstReqCycle, 32'd12);
    checkWrite("restartWrite0", 0, 32'h78_310311);
    checkOutput("restartIndex", {22'b0, lut_index}, 32'd0);

    // Full table with no terminator: index saturates at 1023, no wrap to entry 0.
    for (int i = 0; i < 1024; i++) lutMem[i] = {8'h78, 16'h4000 + 16'(i), 8'(i)};
    applyReset();
    releaseReset();
    runUntilEnd(20000);
    checkOutput("fullReqCount", reqCount, 32'd1024);
    checkWrite("fullWriteLast", 1023, 32'h78_43FFFF);
    checkOutput("fullIndex", {22'b0, lut_index}, 32'd1023);
    checkOutput("fullDone", {30'b0, config_done, config_fail}, 32'd2);
    repeat (10) applyStimulus();
    checkOutput("fullNoWrap", reqCount, 32'd1024);
    checkOutput("fullStable", stableErr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
